// File: rtl/fpga_serial_prog_master.sv
// Chip programmer: pulses chip reset, shifts one config frame over sclk/sdout,
// then waits for the chip's ready flag with a timeout. Single clock domain.
module fpga_serial_prog_master #(
    parameter int unsigned       DATA_W        = 5,
    parameter int unsigned       HALF_DIV      = 16,
    parameter int unsigned       RST_CYCLES    = 2,
    parameter bit                LSB_FIRST     = 1'b1,
    parameter bit                WAIT_READY    = 1'b1,
    parameter int unsigned       READY_TIMEOUT = 1024,
    parameter bit                AUTO_START    = 1'b1,
    parameter logic [DATA_W-1:0] INIT_DATA     = '1
) (
    input  logic              i_mainclk,
    input  logic              i_resetbFPGA,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_resetbAll,
    output logic              o_sclk,
    output logic              o_sdout,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_timeout
);

    localparam int RCW = $clog2(RST_CYCLES) + 1;
    localparam int DVW = $clog2(2 * HALF_DIV) + 1;
    localparam int BCW = $clog2(DATA_W) + 1;
    localparam int TCW = $clog2(READY_TIMEOUT) + 1;

    localparam logic [RCW-1:0] RC_LAST = RCW'(RST_CYCLES - 1);
    localparam logic [DVW-1:0] DV_HALF = DVW'(HALF_DIV - 1);
    localparam logic [DVW-1:0] DV_LAST = DVW'(2 * HALF_DIV - 1);
    localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_W - 1);
    localparam logic [TCW-1:0] TC_LIM  = TCW'(READY_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CRST,
        S_SHIFT,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [RCW-1:0]    rcnt_q, rcnt_d;
    logic [DVW-1:0]    div_q, div_d;
    logic [BCW-1:0]    bcnt_q, bcnt_d;
    logic [TCW-1:0]    tcnt_q, tcnt_d;
    logic              rdy_s1_q, rdy_s2_q;
    logic              auto_q, auto_d;
    logic              resetb_q, resetb_d;
    logic              sclk_q, sclk_d;
    logic              sdout_q, sdout_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tmo_q, tmo_d;
    logic              accept;
    logic [DATA_W-1:0] shift_nxt;

    function automatic logic head(input logic [DATA_W-1:0] v);
        return LSB_FIRST ? v[0] : v[DATA_W-1];
    endfunction

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        rcnt_d    = rcnt_q;
        div_d     = div_q;
        bcnt_d    = bcnt_q;
        tcnt_d    = tcnt_q;
        auto_d    = 1'b0;
        resetb_d  = 1'b1;
        sclk_d    = 1'b1;
        sdout_d   = 1'b0;
        busy_d    = busy_q;
        done_d    = done_q;
        tmo_d     = tmo_q;
        accept    = 1'b0;
        shift_nxt = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                accept = i_start || auto_q;
            end
            S_CRST: begin
                if (rcnt_q == RC_LAST) begin
                    state_d = S_SHIFT;
                    div_d   = '0;
                    bcnt_d  = '0;
                    sclk_d  = 1'b0;
                    sdout_d = head(shift_q);
                end else begin
                    rcnt_d   = rcnt_q + 1'b1;
                    resetb_d = 1'b0;
                end
            end
            S_SHIFT: begin
                sclk_d  = sclk_q;
                sdout_d = sdout_q;
                if (div_q == DV_LAST) begin
                    if (bcnt_q == BC_LAST) begin
                        sclk_d  = 1'b1;
                        sdout_d = 1'b0;
                        tcnt_d  = '0;
                        if (WAIT_READY) begin
                            state_d = S_WAIT;
                        end else begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        shift_d = shift_nxt;
                        bcnt_d  = bcnt_q + 1'b1;
                        div_d   = '0;
                        sclk_d  = 1'b0;
                        sdout_d = head(shift_nxt);
                    end
                end else begin
                    div_d = div_q + 1'b1;
                    if (div_q == DV_HALF) begin
                        sclk_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                tcnt_d = tcnt_q + 1'b1;
                // ready beats the limit when both land in the same cycle
                if (rdy_s2_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (tcnt_d == TC_LIM) begin
                    state_d = S_ERR;
                    tmo_d   = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            state_d  = S_CRST;
            shift_d  = auto_q ? INIT_DATA : i_data;
            rcnt_d   = '0;
            resetb_d = 1'b0;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            tmo_d    = 1'b0;
        end
    end

    always_ff @(posedge i_mainclk or negedge i_resetbFPGA) begin
        if (!i_resetbFPGA) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            rcnt_q   <= '0;
            div_q    <= '0;
            bcnt_q   <= '0;
            tcnt_q   <= '0;
            rdy_s1_q <= 1'b0;
            rdy_s2_q <= 1'b0;
            auto_q   <= AUTO_START;
            resetb_q <= 1'b0;
            sclk_q   <= 1'b1;
            sdout_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            rcnt_q   <= rcnt_d;
            div_q    <= div_d;
            bcnt_q   <= bcnt_d;
            tcnt_q   <= tcnt_d;
            rdy_s1_q <= i_ready;
            rdy_s2_q <= rdy_s1_q;
            auto_q   <= auto_d;
            resetb_q <= resetb_d;
            sclk_q   <= sclk_d;
            sdout_q  <= sdout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tmo_q    <= tmo_d;
        end
    end

    assign o_resetbAll = resetb_q;
    assign o_sclk      = sclk_q;
    assign o_sdout     = sdout_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_timeout   = tmo_q;

endmodule
